// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues one outstanding request to
// instruction memory, registers the returned instruction and its PC, and
// hands them to decode over a valid/ready handshake. Redirects from
// branch/jump resolution replace the PC and discard any in-flight fetch.
// Optional macro IF_FETCH_PERF_CNT_EN adds decode transfer and stall counters.
module if_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_rvalid,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [ADDR_W-1:0] if_pc
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {F_REQ, F_WAIT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              drop_q, drop_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [ADDR_W-1:0] redirect_tgt;

  // Masking (rather than slicing) keeps every redirect_pc bit in use.
  assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;
`endif

  // State register: all fetch state, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= F_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_inst_q  <= NOP_INST;
      if_pc_q    <= RESET_PC;
`ifdef IF_FETCH_PERF_CNT_EN
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
`ifdef IF_FETCH_PERF_CNT_EN
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
`endif
    end
  end

  // Next-state: request issue, response capture/discard, redirect override.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;

    if (if_valid_q && id_ready) begin
      if_valid_d = 1'b0;
    end

    if (state_q == F_REQ) begin
      if (imem_req) begin
        req_pc_d = pc_q;
        state_d  = F_WAIT;
      end
    end else begin
      if (imem_rvalid) begin
        state_d = F_REQ;
        drop_d  = 1'b0;
        if (!drop_q && !redirect_en) begin
          if_inst_d  = imem_rdata;
          if_pc_d    = req_pc_q;
          if_valid_d = 1'b1;
          pc_d       = req_pc_q + ADDR_W'(4);
        end
      end else if (redirect_en) begin
        drop_d = 1'b1;
      end
    end

    if (redirect_en) begin
      pc_d       = redirect_tgt;
      if_valid_d = 1'b0;
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  // Performance counters: decode transfers and decode-side stall cycles.
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (if_valid_q && id_ready) begin
      perf_fetch_d = perf_fetch_q + 32'd1;
    end
    if (if_valid_q && !id_ready) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

  // Outputs: request strobe/address and the registered decode interface.
  always_comb begin
    imem_req  = !rst && (state_q == F_REQ) && !redirect_en &&
                (!if_valid_q || id_ready);
    imem_addr = pc_q;
    if_valid  = if_valid_q;
    if_inst   = if_inst_q;
    if_pc     = if_pc_q;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode/control stage.
- Holds the PC and issues single-outstanding requests to instruction memory.
- Registers the returned instruction and its PC, and hands them to decode over a valid/ready handshake.
- Accepts PC redirects from branch, jal and jalr resolution, and discards stale in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32: PC and address width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request strobe, one cycle per request.
- imem_addr  out  ADDR_W  word-aligned fetch address; valid when imem_req=1.
- imem_rdata  in  32  instruction data; valid when imem_rvalid=1.
- imem_rvalid  in  1  response strobe; at most one per request, arriving 1 or more cycles after the request.
- redirect_en  in  1  PC redirect from the branch/jump logic.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] are forced to 0.
- id_ready  in  1  decode can accept an instruction this cycle.
- if_valid  out  1  if_inst and if_pc hold a valid instruction.
- if_inst  out  32  fetched instruction to decode.
- if_pc  out  ADDR_W  address of if_inst.

Behaviour:
- Registers: pc, req_pc, drop, state in {F_REQ, F_WAIT}, and the output register (if_valid, if_inst, if_pc).
- Reset (rst=1 at an edge), also when asserted mid-operation:
  - pc=RESET_PC, state=F_REQ, drop=0, if_valid=0, if_inst=32'h0000_0013 (nop), if_pc=RESET_PC.
  - imem_req is forced to 0 while rst=1.
  - A response arriving after reset, for a pre-reset request, is ignored because state is F_REQ.
- Handshake to decode:
  - A transfer occurs when if_valid && id_ready; if_valid then clears unless reloaded the same edge.
  - While if_valid && !id_ready, if_inst and if_pc hold stable.
- F_REQ:
  - imem_req = !redirect_en && (!if_valid || id_ready); imem_addr = pc.
  - When imem_req=1: req_pc<=pc, state<=F_WAIT.
  - Otherwise state stays F_REQ.
- F_WAIT:
  - imem_req=0.
  - On imem_rvalid with drop=0 and redirect_en=0: if_inst<=imem_rdata, if_pc<=req_pc, if_valid<=1, pc<=req_pc+4 (wraps mod 2^ADDR_W), state<=F_REQ.
  - On imem_rvalid with drop=1 or redirect_en=1: response is discarded, drop<=0, state<=F_REQ.
  - A response is never delivered to decode once a redirect has occurred since its request.
- Redirect (highest priority, any state):
  - pc<={redirect_pc[ADDR_W-1:2],2'b00} and if_valid<=0 at the same edge; the current if_inst is flushed even if id_ready=1.
  - In F_WAIT without imem_rvalid: drop<=1 and state stays F_WAIT.
  - In F_REQ: no request is issued that cycle.
  - Redirect during a stall (if_valid=1, id_ready=0): the held instruction is flushed.
  - Back-to-back redirects: the last target wins; drop stays 1.
- Timing and constraints:
  - imem_rvalid in F_REQ is ignored.
  - Best-case latency: request at cycle n, rvalid at n+1, if_valid at n+2.
  - Peak throughput is 1 instruction per 2 cycles.
  - Only one request is ever outstanding.

Optional Feature:
- Macro: IF_FETCH_PERF_CNT_EN.
- When defined, adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0 and wrapping.
  - perf_fetch_cnt increments on each decode transfer (if_valid && id_ready).
  - perf_stall_cnt increments each cycle with if_valid && !id_ready.
  - Discarded responses increment neither counter.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, memory returns rdata=32'h00500093 one cycle after each request, id_ready=1 -> imem_addr=0x0 then 0x4; first if_valid=1 at cycle 2 with if_pc=0x0; if_valid pulses every 2 cycles; PCs increment by 4.
- Hold id_ready=0 for 5 cycles after the first instruction -> if_inst/if_pc stable, no new imem_req; resumes at addr 0x4 once id_ready=1.
- redirect_en=1 with redirect_pc=0x103 while in F_WAIT, rvalid one cycle later -> response discarded, if_valid stays 0, next imem_addr=0x100.
- redirect_en coincident with imem_rvalid -> no delivery; next imem_addr equals the redirect target.
- rst asserted in F_WAIT, then stale imem_rvalid the cycle after release -> ignored; first request to RESET_PC; if_valid=0 until its response.
- pc=0xFFFF_FFFC fetch completes -> next imem_addr=0x0000_0000 (wrap).
